// File: rtl/grf_wport_arb_pkg.sv
// Shared CPU datapath package: write-port arbiter state encoding and defaults.
package grf_wport_arb_pkg;

  typedef enum logic {
    PRI_P   = 1'b0,
    FORCE_M = 1'b1
  } arb_state_e;

  localparam int unsigned STARVE_MAX_DEF = 3;

endpackage

// File: rtl/grf_wport_reg.sv
// Register-file write-port register: we pulses on load, payload holds otherwise.
module grf_wport_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld,
  input  logic [4:0]  ld_a3,
  input  logic [31:0] ld_wd,
  input  logic [31:0] ld_pc,
  output logic        we,
  output logic [4:0]  a3,
  output logic [31:0] wd,
  output logic [31:0] pc_w
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we   <= 1'b0;
      a3   <= '0;
      wd   <= '0;
      pc_w <= '0;
    end else begin
      we <= ld;
      if (ld) begin
        a3   <= ld_a3;
        wd   <= ld_wd;
        pc_w <= ld_pc;
      end
    end
  end

endmodule

// File: rtl/grf_wport_arb.sv
// Arbitrates pipeline (P) and multi-cycle unit (M) writebacks onto one GRF write
// port. P has priority; M is forced a grant after STARVE_MAX consecutive denials.
module grf_wport_arb
  import grf_wport_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_valid,
  input  logic [4:0]  p_a3,
  input  logic [31:0] p_wd,
  input  logic [31:0] p_pc,
  output logic        p_ready,
  input  logic        m_valid,
  input  logic [4:0]  m_a3,
  input  logic [31:0] m_wd,
  input  logic [31:0] m_pc,
  output logic        m_ready,
  output logic        we,
  output logic [4:0]  a3,
  output logic [31:0] wd,
  output logic [31:0] pc_w,
  output logic        starved
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  arb_state_e  state, state_nxt;
  logic [3:0]  starve_cnt, cnt_nxt;
  logic [4:0]  sel_a3;
  logic [31:0] sel_wd, sel_pc;

  // Readies are gated by reset so nothing handshakes while reset is held.
  always_comb begin
    p_ready = 1'b0;
    m_ready = 1'b0;
    if (reset) begin
      if (state == FORCE_M) begin
        m_ready = m_valid;
        p_ready = p_valid && !m_valid;
      end else begin
        p_ready = p_valid;
        m_ready = m_valid && !p_valid;
      end
    end
  end

  always_comb begin
    cnt_nxt   = '0;
    state_nxt = state;
    if (m_valid && !m_ready)
      cnt_nxt = (starve_cnt >= SMAX) ? SMAX : starve_cnt + 4'd1;
    case (state)
      PRI_P:   if (cnt_nxt == SMAX) state_nxt = FORCE_M;
      FORCE_M: if (m_ready || !m_valid) state_nxt = PRI_P;
      default: state_nxt = PRI_P;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= PRI_P;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= cnt_nxt;
    end
  end

  assign starved = (state == FORCE_M);

  always_comb begin
    sel_a3 = p_a3;
    sel_wd = p_wd;
    sel_pc = p_pc;
    if (m_ready) begin
      sel_a3 = m_a3;
      sel_wd = m_wd;
      sel_pc = m_pc;
    end
  end

  grf_wport_reg u_wport_reg (
    .clk   (clk),
    .reset (reset),
    .ld    (p_ready | m_ready),
    .ld_a3 (sel_a3),
    .ld_wd (sel_wd),
    .ld_pc (sel_pc),
    .we    (we),
    .a3    (a3),
    .wd    (wd),
    .pc_w  (pc_w)
  );

endmodule

// File: tb/tb_grf_wport_arb.sv
// Directed bench for grf_wport_arb with hand-computed expectations.
module tb_grf_wport_arb;

  localparam int SM = 3;

  logic        clk, reset;
  logic        p_valid, m_valid, p_ready, m_ready;
  logic [4:0]  p_a3, m_a3, a3;
  logic [31:0] p_wd, p_pc, m_wd, m_pc, wd, pc_w;
  logic        we, starved;

  int checks = 0;
  int fails  = 0;

  grf_wport_arb #(.STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .p_valid(p_valid), .p_a3(p_a3), .p_wd(p_wd), .p_pc(p_pc), .p_ready(p_ready),
    .m_valid(m_valid), .m_a3(m_a3), .m_wd(m_wd), .m_pc(m_pc), .m_ready(m_ready),
    .we(we), .a3(a3), .wd(wd), .pc_w(pc_w), .starved(starved)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Protocol invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if (p_ready && m_ready) begin
        fails++; $display("FAIL inv_mutex p_ready=%0b m_ready=%0b required not both", p_ready, m_ready);
      end
      if ((p_ready && !p_valid) || (m_ready && !m_valid)) begin
        fails++; $display("FAIL inv_ready_valid p_rdy=%0b p_vld=%0b m_rdy=%0b m_vld=%0b", p_ready, p_valid, m_ready, m_valid);
      end
      if (dut.starve_cnt > 4'(SM)) begin
        fails++; $display("FAIL inv_starve_cnt got=%0d max=%0d", dut.starve_cnt, SM);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; p_valid = 1'b0; m_valid = 1'b0;
    p_a3 = '0; p_wd = '0; p_pc = '0; m_a3 = '0; m_wd = '0; m_pc = '0;
    #3;
    checks++;
    if ({we, a3, wd, pc_w, starved} !== 71'd0) begin
      fails++; $display("FAIL reset_outputs got we=%0b a3=%0d wd=%h pc=%h st=%0b required all 0", we, a3, wd, pc_w, starved);
    end
    p_valid = 1'b1; m_valid = 1'b1; #1;
    checks++;
    if ({p_ready, m_ready} !== 2'b00) begin
      fails++; $display("FAIL reset_ready got=%b required=00", {p_ready, m_ready});
    end
    @(posedge clk); #1;
    checks++;
    if (we !== 1'b0) begin
      fails++; $display("FAIL reset_no_we got=%0b required=0", we);
    end
    p_valid = 1'b0; m_valid = 1'b0; reset = 1'b1;
    next_cycle();
  endtask

  task automatic test_p_only();
    p_valid = 1'b1; p_a3 = 5'd5; p_wd = 32'h1234_5678; p_pc = 32'h3000; #1;
    checks++;
    if ({p_ready, m_ready} !== 2'b10) begin
      fails++; $display("FAIL p_only_ready got=%b required=10", {p_ready, m_ready});
    end
    next_cycle(); p_valid = 1'b0;
    checks++;
    if (we !== 1'b1 || a3 !== 5'd5 || wd !== 32'h1234_5678 || pc_w !== 32'h3000) begin
      fails++; $display("FAIL p_only_write got we=%0b a3=%0d wd=%h pc=%h required 1/5/12345678/3000", we, a3, wd, pc_w);
    end
    next_cycle();
    checks++;
    if (we !== 1'b0 || a3 !== 5'd5 || wd !== 32'h1234_5678) begin
      fails++; $display("FAIL p_only_hold got we=%0b a3=%0d wd=%h required 0/5/12345678", we, a3, wd);
    end
  endtask

  task automatic test_m_only();
    m_valid = 1'b1; m_a3 = 5'd9; m_wd = 32'hDEAD_BEEF; m_pc = 32'h4004; #1;
    checks++;
    if ({p_ready, m_ready} !== 2'b01) begin
      fails++; $display("FAIL m_only_ready got=%b required=01", {p_ready, m_ready});
    end
    next_cycle(); m_valid = 1'b0;
    checks++;
    if (we !== 1'b1 || a3 !== 5'd9 || wd !== 32'hDEAD_BEEF || pc_w !== 32'h4004) begin
      fails++; $display("FAIL m_only_write got we=%0b a3=%0d wd=%h pc=%h required 1/9/deadbeef/4004", we, a3, wd, pc_w);
    end
    next_cycle();
  endtask

  task automatic test_starve();
    logic exp_m;
    p_valid = 1'b1; p_a3 = 5'd1; p_wd = 32'hA0; p_pc = 32'h100;
    m_valid = 1'b1; m_a3 = 5'd2; m_wd = 32'hB0; m_pc = 32'h200;
    for (int c = 0; c < 5; c++) begin
      exp_m = (c == SM);
      #1;
      checks++;
      if ({p_ready, m_ready, starved} !== {!exp_m, exp_m, exp_m}) begin
        fails++; $display("FAIL starve_grant cyc=%0d got p/m/st=%b required=%b", c, {p_ready, m_ready, starved}, {!exp_m, exp_m, exp_m});
      end
      @(posedge clk); #1;
      checks++;
      if (we !== 1'b1 || a3 !== (exp_m ? 5'd2 : 5'd1) || wd !== (exp_m ? 32'hB0 : 32'hA0)) begin
        fails++; $display("FAIL starve_write cyc=%0d got we=%0b a3=%0d wd=%h required m=%0b", c, we, a3, wd, exp_m);
      end
    end
    p_valid = 1'b0; m_valid = 1'b0;
    next_cycle();
  endtask

  task automatic test_a3_zero();
    p_valid = 1'b1; p_a3 = 5'd0; p_wd = 32'h55; p_pc = 32'h500;
    m_valid = 1'b1; m_a3 = 5'd7; m_wd = 32'h77; m_pc = 32'h700; #1;
    checks++;
    if ({p_ready, m_ready} !== 2'b10) begin
      fails++; $display("FAIL a3z_p_grant got=%b required=10", {p_ready, m_ready});
    end
    next_cycle(); p_valid = 1'b0; #1;
    checks++;
    if (we !== 1'b1 || a3 !== 5'd0 || wd !== 32'h55) begin
      fails++; $display("FAIL a3z_write got we=%0b a3=%0d wd=%h required 1/0/55", we, a3, wd);
    end
    checks++;
    if ({p_ready, m_ready} !== 2'b01) begin
      fails++; $display("FAIL a3z_m_grant got=%b required=01", {p_ready, m_ready});
    end
    next_cycle(); m_valid = 1'b0;
    checks++;
    if (we !== 1'b1 || a3 !== 5'd7 || wd !== 32'h77 || pc_w !== 32'h700) begin
      fails++; $display("FAIL a3z_m_write got we=%0b a3=%0d wd=%h pc=%h required 1/7/77/700", we, a3, wd, pc_w);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    p_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      p_a3 = 5'(10 + i); p_wd = 32'hC000 + 32'(i); p_pc = 32'h800 + 32'(4 * i);
      next_cycle();
      checks++;
      if (we !== 1'b1 || a3 !== 5'(10 + i) || wd !== 32'hC000 + 32'(i) || pc_w !== 32'h800 + 32'(4 * i)) begin
        fails++; $display("FAIL b2b_write i=%0d got we=%0b a3=%0d wd=%h pc=%h", i, we, a3, wd, pc_w);
      end
    end
    p_valid = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset_mid();
    p_valid = 1'b1; p_a3 = 5'd3; p_wd = 32'hF0; p_pc = 32'h900;
    m_valid = 1'b1; m_a3 = 5'd4; m_wd = 32'hF1; m_pc = 32'h904;
    for (int c = 0; c < SM; c++) next_cycle();
    checks++;
    if (we !== 1'b1 || starved !== 1'b1) begin
      fails++; $display("FAIL rstmid_pre got we=%0b st=%0b required 1/1", we, starved);
    end
    #2 reset = 1'b0; #1;
    checks++;
    if ({we, a3, wd, pc_w, starved, p_ready, m_ready} !== 73'd0) begin
      fails++; $display("FAIL rstmid_async got we=%0b a3=%0d wd=%h pc=%h st=%0b pr=%0b mr=%0b required all 0", we, a3, wd, pc_w, starved, p_ready, m_ready);
    end
    m_valid = 1'b0; p_a3 = 5'd6; p_wd = 32'hE0; p_pc = 32'hA00;
    #1 reset = 1'b1; #1;
    checks++;
    if (p_ready !== 1'b1) begin
      fails++; $display("FAIL rstmid_ready got=%0b required=1", p_ready);
    end
    next_cycle(); p_valid = 1'b0;
    checks++;
    if (we !== 1'b1 || a3 !== 5'd6 || wd !== 32'hE0 || pc_w !== 32'hA00) begin
      fails++; $display("FAIL rstmid_write got we=%0b a3=%0d wd=%h pc=%h required 1/6/e0/a00", we, a3, wd, pc_w);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_p_only();
    test_m_only();
    test_starve();
    test_a3_zero();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/grf_wport_arb.md
GRF_WPORT_ARB -- requirements
Module: grf_wport_arb

Interface
REQ-001 Parameter STARVE_MAX, default 3: number of consecutive denied cycles of the M requester before it is forced a grant; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-004 p_valid  input  1  pipeline writeback request.
REQ-005 p_a3 / p_wd / p_pc  input  5 / 32 / 32  pipeline destination register, write data, PC.
REQ-006 p_ready  output  1  pipeline request accepted this cycle.
REQ-007 m_valid  input  1  multi-cycle-unit writeback request.
REQ-008 m_a3 / m_wd / m_pc  input  5 / 32 / 32  multi-cycle-unit destination register, write data, PC.
REQ-009 m_ready  output  1  multi-cycle-unit request accepted this cycle.
REQ-010 we / a3 / wd / pc_w  output  1 / 5 / 32 / 32  registered register-file write port: WE, A3, WD, PC_W.
REQ-011 starved  output  1  high while the FSM is in state FORCE_M.

Function
REQ-012 A handshake occurs on a requester when its valid and ready are both 1 in the same cycle; payload is sampled on that edge.
REQ-013 At most one of p_ready, m_ready SHALL be 1 in any cycle.
REQ-014 p_ready and m_ready are combinational from valids and FSM state; ready is never asserted without the matching valid.
REQ-015 FSM states: PRI_P (pipeline has priority) and FORCE_M (M has priority).
REQ-016 In PRI_P: p_valid=1 grants P; otherwise m_valid=1 grants M.
REQ-017 In FORCE_M: m_valid=1 grants M; otherwise p_valid=1 grants P.
REQ-018 starve_cnt (4 bits) increments, saturating at STARVE_MAX, in each cycle with m_valid=1 and m_ready=0; it clears to 0 on any M handshake or any cycle with m_valid=0.
REQ-019 Transition PRI_P -> FORCE_M on the edge where starve_cnt reaches STARVE_MAX; transition FORCE_M -> PRI_P on the edge following an M handshake or a cycle in FORCE_M with m_valid=0.
REQ-020 On a handshake, we, a3, wd, pc_w are loaded with the winner's payload on that same edge (1-cycle latency); with no handshake, we=0 and a3/wd/pc_w hold their previous values.
REQ-021 a3=0 requests are arbitrated and forwarded unchanged with we=1; discarding $0 writes is the register file's responsibility.
REQ-022 Both valids high in the same cycle: exactly one grant per REQ-016/017; the loser holds valid and payload stable until granted.
REQ-023 Sustained p_valid=1 with m_valid=1: M is granted no later than the (STARVE_MAX+2)-th cycle of m_valid.

Reset
REQ-024 While reset=0: we=0, a3=0, wd=0, pc_w=0, starve_cnt=0, state=PRI_P, starved=0, p_ready=0, m_ready=0, independent of clk.
REQ-025 Reset assertion mid-arbitration discards any in-flight grant; first grant possible in the first cycle after release.

Structure
REQ-026 State encoding (PRI_P, FORCE_M) and the default STARVE_MAX value SHALL reside in the shared CPU package used by the datapath modules.
REQ-027 The output port register SHALL be a sub-module grf_wport_reg (load-enable register for we/a3/wd/pc_w, async active-low clear); arbitration logic and FSM remain in grf_wport_arb.

Verification
REQ-028 Only p_valid=1, p_a3=5, p_wd=0x12345678, p_pc=0x3000 for 1 cycle -> p_ready=1 that cycle; next cycle we=1, a3=5, wd=0x12345678, pc_w=0x3000; following cycle we=0.
REQ-029 Only m_valid=1, m_a3=9, m_wd=0xDEADBEEF -> m_ready=1 immediately; next cycle we=1, a3=9, wd=0xDEADBEEF.
REQ-030 STARVE_MAX=3, p_valid and m_valid held high -> P granted cycles 0-2, M granted cycle 3 with starved=1, P granted cycle 4 with starved=0.
REQ-031 Both valid with p_a3=0 -> P granted, next cycle we=1, a3=0; M granted next cycle.
REQ-032 reset driven to 0 mid-cycle after a grant, between clock edges -> we, a3, wd, pc_w, starved go to 0 immediately without a clock edge; after release with p_valid=1, grant on the first cycle.
REQ-033 Assertions throughout all tests: never p_ready&&m_ready; a requester's ready never asserted while its valid=0; starve_cnt never exceeds STARVE_MAX.
